udp_payload_buffer: RTL and testbench

- Sits directly downstream of `combine_decoder` on its UDP payload port.
- Accepts the 32-bit payload words the decoder emits with `wr_en_udp` and holds each packet tentatively until the decoder's end-of-packet verdict.
- If `ok_udp` is high on the `fin_udp` cycle, it commits the packet. Otherwise it discards the packet and rolls the write pointer back.
- Committed packets are replayed MSB-first as a byte stream with a valid/ready handshake and a last-byte marker, for the application/host side.

---
 rtl/udp_payload_buffer_if.sv | 26 ++
 rtl/udp_payload_buffer.sv | 192 +++++++++++++++++++
 tb/tb_udp_payload_buffer.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/udp_payload_buffer_if.sv
// Bus bundle for udp_payload_buffer: decoder-side write port and byte-stream read port.
interface udp_payload_buffer_if;
  logic [31:0] data_in;
  logic        wr_en;
  logic [15:0] len;
  logic        ok;
  logic        fin;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready;
  logic        rd_last;
  logic [15:0] pkt_len;
  logic        pkt_avail;
  logic [15:0] drop_cnt;
  logic [15:0] pkt_cnt;

  modport master (
    output data_in, wr_en, len, ok, fin, rd_ready,
    input  rd_data, rd_valid, rd_last, pkt_len, pkt_avail, drop_cnt, pkt_cnt
  );

  modport slave (
    input  data_in, wr_en, len, ok, fin, rd_ready,
    output rd_data, rd_valid, rd_last, pkt_len, pkt_avail, drop_cnt, pkt_cnt
  );
endinterface

// File: rtl/udp_payload_buffer.sv
// Tentative-commit UDP payload buffer replayed as a byte stream.
// UDP_BUF_STATS_EN enables the drop_cnt/pkt_cnt counters (tied to 0 otherwise).
//
// state    | meaning
// S_IDLE   | no packet in flight; pops next descriptor when queue non-empty
// S_LOAD   | synchronous RAM read of word at rp
// S_STREAM | presenting byte bsel of the registered word
module udp_payload_buffer #(
  parameter int ADDR_W = 9,
  parameter int LQ_AW  = 3
) (
  input logic clk,
  input logic reset,
  udp_payload_buffer_if.slave bus
);
  localparam int PW    = ADDR_W + 1;
  localparam int DEPTH = 1 << ADDR_W;
  localparam int QD    = 1 << LQ_AW;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_t;

  logic [31:0]   mem [DEPTH];
  logic [PW-1:0] q_wcnt [QD];
  logic [15:0]   q_len [QD];

  logic [PW-1:0] wp_tmp, wp_cmt, rp, end_ptr, wcnt;
  logic          ovf;
  logic [LQ_AW:0] q_wp, q_rp;

  logic [PW-1:0]  fill, wp_inc, wcnt_n;
  logic [LQ_AW:0] q_used;
  logic [16:0]    len_words;
  logic           space_ok, wr_ok, ovf_n, q_empty, q_full, len_ok, commit, drop;

  state_t      state, state_n;
  logic        pop;
  logic [31:0] word_q;
  logic [15:0] bytes_left, pkt_len_q;
  logic [1:0]  bsel;
  logic [7:0]  rd_data_c;
  logic        rd_valid_c, rd_last_c;

  // Occupancy never exceeds DEPTH, so the top bit alone flags "full".
  assign fill      = wp_tmp - rp;
  assign space_ok  = ~fill[ADDR_W];
  assign wr_ok     = bus.wr_en & space_ok;
  assign wp_inc    = wp_tmp + PW'(wr_ok);
  assign wcnt_n    = wcnt + PW'(wr_ok);
  assign ovf_n     = ovf | (bus.wr_en & ~space_ok);
  assign q_used    = q_wp - q_rp;
  assign q_empty   = (q_used == '0);
  assign q_full    = q_used[LQ_AW];
  assign len_words = ({1'b0, bus.len} + 17'd3) >> 2;
  assign len_ok    = (32'(len_words) <= 32'(wcnt_n));
  assign commit    = bus.fin & bus.ok & ~ovf_n & ~q_full & (bus.len != 16'd0) & len_ok;
  assign drop      = bus.fin & ~commit & ((bus.len != 16'd0) | (wcnt_n != '0));

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp_tmp[ADDR_W-1:0]] <= bus.data_in;
  end

  always_ff @(posedge clk) begin
    if (commit) begin
      q_wcnt[q_wp[LQ_AW-1:0]] <= wcnt_n;
      q_len[q_wp[LQ_AW-1:0]]  <= bus.len;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_tmp <= '0;
      wp_cmt <= '0;
      wcnt   <= '0;
      ovf    <= 1'b0;
      q_wp   <= '0;
    end else if (bus.fin) begin
      wcnt <= '0;
      ovf  <= 1'b0;
      if (commit) begin
        wp_tmp <= wp_inc;
        wp_cmt <= wp_inc;
        q_wp   <= q_wp + 1'b1;
      end else if (drop) begin
        wp_tmp <= wp_cmt;
      end else begin
        wp_tmp <= wp_inc;
      end
    end else begin
      wp_tmp <= wp_inc;
      wcnt   <= wcnt_n;
      ovf    <= ovf_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    pop        = 1'b0;
    rd_valid_c = 1'b0;
    rd_last_c  = 1'b0;
    rd_data_c  = 8'h00;
    case (state)
      S_IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          state_n = S_LOAD;
        end
      end
      S_LOAD: state_n = S_STREAM;
      S_STREAM: begin
        rd_valid_c = 1'b1;
        rd_last_c  = (bytes_left == 16'd1);
        case (bsel)
          2'd0:    rd_data_c = word_q[31:24];
          2'd1:    rd_data_c = word_q[23:16];
          2'd2:    rd_data_c = word_q[15:8];
          default: rd_data_c = word_q[7:0];
        endcase
        if (bus.rd_ready) begin
          if (bytes_left == 16'd1) state_n = S_IDLE;
          else if (bsel == 2'd3)   state_n = S_LOAD;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rp         <= '0;
      end_ptr    <= '0;
      bytes_left <= '0;
      bsel       <= '0;
      pkt_len_q  <= '0;
      word_q     <= '0;
      q_rp       <= '0;
    end else begin
      if (pop) begin
        q_rp       <= q_rp + 1'b1;
        pkt_len_q  <= q_len[q_rp[LQ_AW-1:0]];
        bytes_left <= q_len[q_rp[LQ_AW-1:0]];
        end_ptr    <= rp + q_wcnt[q_rp[LQ_AW-1:0]];
        bsel       <= '0;
      end
      if (state == S_LOAD) word_q <= mem[rp[ADDR_W-1:0]];
      if (state == S_STREAM && bus.rd_ready) begin
        bytes_left <= bytes_left - 16'd1;
        if (bytes_left == 16'd1) begin
          // Jump past any words written beyond the declared length.
          rp        <= end_ptr;
          bsel      <= '0;
          pkt_len_q <= '0;
        end else if (bsel == 2'd3) begin
          rp   <= rp + 1'b1;
          bsel <= '0;
        end else begin
          bsel <= bsel + 2'd1;
        end
      end
    end
  end

  assign bus.rd_data   = rd_data_c;
  assign bus.rd_valid  = rd_valid_c;
  assign bus.rd_last   = rd_last_c;
  assign bus.pkt_len   = pkt_len_q;
  assign bus.pkt_avail = ~q_empty;

`ifdef UDP_BUF_STATS_EN
  logic [15:0] drop_cnt_q, pkt_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      drop_cnt_q <= '0;
      pkt_cnt_q  <= '0;
    end else begin
      if (commit) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign bus.drop_cnt = drop_cnt_q;
  assign bus.pkt_cnt  = pkt_cnt_q;
`else
  assign bus.drop_cnt = 16'd0;
  assign bus.pkt_cnt  = 16'd0;
`endif
endmodule

// File: tb/tb_udp_payload_buffer.sv
// Scoreboard bench for udp_payload_buffer (small RAM so overflow and wrap are reachable).
module tb_udp_payload_buffer;
`ifdef UDP_BUF_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  udp_payload_buffer_if bus ();

  udp_payload_buffer #(.ADDR_W(2), .LQ_AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int accepted = 0;
  int exp_drop = 0;
  int exp_pkt = 0;
  bit bp_mode = 1'b0;
  logic [24:0] sb [$];
  logic [31:0] wbuf [8];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send_pkt(input int n, input logic [15:0] l, input logic ok_v, input bit exp_commit);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      bus.wr_en   = 1'b1;
      bus.data_in = wbuf[i];
    end
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    bus.fin   = 1'b1;
    bus.len   = l;
    bus.ok    = ok_v;
    if (exp_commit) begin
      for (int j = 0; j < int'(l); j++) begin
        logic [31:0] w;
        w = wbuf[j/4] >> (8 * (3 - (j % 4)));
        sb.push_back({(j == int'(l) - 1), l, w[7:0]});
      end
      exp_pkt++;
    end else if (l != 16'd0 || n != 0) begin
      exp_drop++;
    end
    @(posedge clk); #1;
    bus.fin = 1'b0;
    bus.ok  = 1'b0;
    bus.len = 16'd0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(posedge clk);
      t++;
    end
    check_val("drain", sb.size(), 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_counters(input string tag);
    check_val({tag, "_drop_cnt"}, {16'h0, bus.drop_cnt}, STATS ? exp_drop : 0);
    check_val({tag, "_pkt_cnt"}, {16'h0, bus.pkt_cnt}, STATS ? exp_pkt : 0);
  endtask

  task automatic load_hello();
    wbuf[0] = 32'h48656C6C;
    wbuf[1] = 32'h6F20576F;
    wbuf[2] = 32'h726C6400;
  endtask

  int cyc = 0;
  initial begin
    bus.rd_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.rd_ready = bp_mode ? (cyc % 3 == 0) : 1'b1;
      cyc++;
    end
  end

  // Byte monitor: pops the scoreboard on each handshake and checks held bytes stay put.
  bit held = 1'b0;
  logic [24:0] held_val;
  always @(negedge clk) begin
    if (reset) begin
      held = 1'b0;
    end else begin
      if (held && bus.rd_valid)
        check_val("hold", {7'h0, bus.rd_last, bus.pkt_len, bus.rd_data}, {7'h0, held_val});
      if (bus.rd_valid && bus.rd_ready) begin
        accepted++;
        if (sb.size() == 0) begin
          check_val("extra_byte", {24'h0, bus.rd_data}, 32'h100);
        end else begin
          logic [24:0] e;
          e = sb.pop_front();
          check_val("byte", {24'h0, bus.rd_data}, {24'h0, e[7:0]});
          check_val("last", {31'h0, bus.rd_last}, {31'h0, e[24]});
          check_val("pkt_len", {16'h0, bus.pkt_len}, {16'h0, e[23:8]});
        end
      end
      held     = bus.rd_valid && !bus.rd_ready;
      held_val = {bus.rd_last, bus.pkt_len, bus.rd_data};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    int target;
    int t;
    bus.data_in = '0;
    bus.wr_en   = 1'b0;
    bus.len     = '0;
    bus.ok      = 1'b0;
    bus.fin     = 1'b0;
    #12;
    check_val("rst_outputs", {bus.rd_data, bus.rd_valid, bus.rd_last, bus.pkt_avail, bus.pkt_len}, 32'h0);
    check_val("rst_cnts", {bus.drop_cnt, bus.pkt_cnt}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Commit with latency checks
    load_hello();
    send_pkt(3, 16'd11, 1'b1, 1'b1);
    check_val("avail_after_fin", {31'h0, bus.pkt_avail}, 32'h1);
    check_val("valid_n0", {31'h0, bus.rd_valid}, 32'h0);
    @(posedge clk); #1;
    check_val("valid_load", {31'h0, bus.rd_valid}, 32'h0);
    check_val("pkt_len_latched", {16'h0, bus.pkt_len}, 32'd11);
    @(posedge clk); #1;
    check_val("valid_first", {31'h0, bus.rd_valid}, 32'h1);
    check_val("first_byte", {24'h0, bus.rd_data}, 32'h48);
    wait_drain();
    check_val("idle_pkt_len", {16'h0, bus.pkt_len}, 32'h0);
    check_counters("commit");

    // Bad verdict drops, then same packet commits
    send_pkt(3, 16'd11, 1'b0, 1'b0);
    vcnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.rd_valid) vcnt++;
    end
    check_val("drop_no_valid", vcnt, 0);
    check_counters("drop");
    send_pkt(3, 16'd11, 1'b1, 1'b1);
    wait_drain();
    check_counters("after_drop");

    // RAM overflow (depth 4): 5-word packet dropped, then 3-word packet intact
    for (int i = 0; i < 5; i++) wbuf[i] = 32'hF0F0F000 + i;
    send_pkt(5, 16'd20, 1'b1, 1'b0);
    check_counters("ovf");
    wbuf[0] = 32'h01020304;
    wbuf[1] = 32'h05060708;
    wbuf[2] = 32'h090A0B0C;
    send_pkt(3, 16'd12, 1'b1, 1'b1);
    wait_drain();

    // Back-pressure
    bp_mode = 1'b1;
    load_hello();
    send_pkt(3, 16'd11, 1'b1, 1'b1);
    wait_drain();
    bp_mode = 1'b0;

    // Extra words beyond len are skipped
    wbuf[0] = 32'hAABBCCDD;
    wbuf[1] = 32'hEEFF0011;
    wbuf[2] = 32'h22334455;
    send_pkt(3, 16'd5, 1'b1, 1'b1);
    wait_drain();
    wbuf[0] = 32'h5A6B7C8D;
    send_pkt(1, 16'd3, 1'b1, 1'b1);
    wait_drain();
    check_counters("extra");

    // Empty fin is silently ignored; short packet is dropped
    send_pkt(0, 16'd0, 1'b0, 1'b0);
    check_counters("silent");
    wbuf[0] = 32'h11111111;
    send_pkt(1, 16'd8, 1'b1, 1'b0);
    check_counters("short");

    // Reset mid-stream after the 4th byte
    load_hello();
    send_pkt(3, 16'd11, 1'b1, 1'b1);
    target = accepted + 4;
    t = 0;
    while (accepted < target && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_val("reset_wait", accepted, target);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    sb.delete();
    exp_drop = 0;
    exp_pkt  = 0;
    check_val("midrst_outputs", {bus.rd_data, bus.rd_valid, bus.rd_last, bus.pkt_avail, bus.pkt_len}, 32'h0);
    check_counters("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    wbuf[0] = 32'hDEADBEEF;
    send_pkt(1, 16'd4, 1'b1, 1'b1);
    wait_drain();
    check_counters("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
